// File: rtl/uart_frame_rx.sv
// Length-prefixed frame collector: buffers L payload bytes from the UART stream, then drains them with tlast.
// Optional trailing XOR checksum byte is enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  output logic                         busy,
  output logic                         len_error,
  output logic                         timeout_error,
  output logic                         checksum_error,
  output logic [1:0]                   dbg_state_o
);
  // Both streams use valid/ready: a beat transfers on a rising clk edge where valid and
  // ready are both high; a source holds data stable while valid is high and ready is low.
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [AW-1:0]         wr_idx_q, wr_idx_d;
  logic [AW-1:0]         rd_idx_q, rd_idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  len_err_q, len_err_d;
  logic                  to_err_q, to_err_d;
  logic                  ck_err_q, ck_err_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_LEN];

  logic s_acc, m_acc, wr_last, rd_last, cnt_term, len_bad;

  assign s_axis_tready = !rst && (state_q != DRAIN);
  assign m_axis_tvalid = (state_q == DRAIN);
  assign m_axis_tdata  = (state_q == DRAIN) ? mem_q[rd_idx_q] : '0;
  assign m_axis_tlast  = (state_q == DRAIN) && rd_last;
  assign frame_len     = len_q;
  assign busy          = (state_q != IDLE);
  assign len_error     = len_err_q;
  assign timeout_error = to_err_q;
  assign dbg_state_o   = state_q;
`ifdef UART_FRAME_CHECKSUM_EN
  assign checksum_error = ck_err_q;
`else
  assign checksum_error = 1'b0;
`endif

  assign s_acc    = s_axis_tvalid && s_axis_tready;
  assign m_acc    = m_axis_tvalid && m_axis_tready;
  assign wr_last  = (LW'(wr_idx_q) == len_q - LW'(1));
  assign rd_last  = (LW'(rd_idx_q) == len_q - LW'(1));
  assign cnt_term = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign len_bad  = (s_axis_tdata == '0) || (s_axis_tdata > DATA_WIDTH'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    len_err_d = 1'b0;
    to_err_d  = 1'b0;
    ck_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_acc) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            len_d    = LW'(s_axis_tdata);
            wr_idx_d = '0;
            rd_idx_d = '0;
            cnt_d    = '0;
            csum_d   = '0;
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        // An accepted byte beats the timeout in the terminal cycle.
        if (s_acc) begin
          cnt_d  = '0;
          csum_d = csum_q ^ s_axis_tdata;
          if (wr_last) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DRAIN;
`endif
          end else begin
            wr_idx_d = wr_idx_q + AW'(1);
          end
        end else if (cnt_term) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CHECK: begin
`ifdef UART_FRAME_CHECKSUM_EN
        if (s_acc) begin
          cnt_d = '0;
          if (s_axis_tdata == csum_q) begin
            state_d = DRAIN;
          end else begin
            ck_err_d = 1'b1;
            state_d  = IDLE;
          end
        end else if (cnt_term) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      DRAIN: begin
        if (m_acc) begin
          if (rd_last) state_d = IDLE;
          else         rd_idx_d = rd_idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      len_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      ck_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      len_err_q <= len_err_d;
      to_err_q  <= to_err_d;
      ck_err_q  <= ck_err_d;
    end
  end

  // Payload storage carries no reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (state_q == COLLECT && s_acc) mem_q[wr_idx_q] <= s_axis_tdata;
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed scoreboard bench for uart_frame_rx; follows UART_FRAME_CHECKSUM_EN when defined.
module tb_uart_frame_rx;
  localparam int DW = 8;
  localparam int ML = 16;
  localparam int TO = 20;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [LW-1:0] frame_len;
  logic          busy, len_error, timeout_error, checksum_error;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_miss = 0;
  int len_err_n = 0;
  int to_err_n = 0;
  int ck_err_n = 0;
  logic [DW:0] exp_q[$];
  logic [DW-1:0] pay [ML];

  always #5 clk = ~clk;

  uart_frame_rx #(.DATA_WIDTH(DW), .MAX_LEN(ML), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .frame_len(frame_len), .busy(busy),
    .len_error(len_error), .timeout_error(timeout_error),
    .checksum_error(checksum_error), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (len_error) len_err_n++;
      if (timeout_error) to_err_n++;
      if (checksum_error) ck_err_n++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_out: got last=%0b data=%0h, expected no output", m_tlast, m_tdata);
        end else begin
          check("m_axis_beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [DW-1:0] b);
    int n = 0;
    @(negedge clk);
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      n_vec++;
      n_miss++;
      $display("FAIL s_accept: tready stayed 0 for byte %0h, expected 1", b);
    end
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic send_cks(input logic [DW-1:0] c);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(c);
`else
    if (c == 8'hxx) $display("unused %0h", c);
`endif
  endtask

  // Sends L, pay[0..L-1] and (when enabled) their XOR; queues the expected beats.
  task automatic send_frame(input int len);
    logic [DW-1:0] c = '0;
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pay[i]});
    send_byte(DW'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(pay[i]);
      c = c ^ pay[i];
    end
    send_cks(c);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (exp_q.size() != 0 || busy)}, 32'd0);
  endtask

  initial begin
    int base;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_outputs", {22'd0, m_tvalid, m_tlast, busy, len_error, timeout_error, checksum_error, m_tdata},
          32'd0);
    check("rst_frame_len", {27'd0, frame_len}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

    // 03,55,A3,FF: tvalid exactly one cycle after the final accept
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hA3});
    exp_q.push_back({1'b1, 8'hFF});
    send_byte(8'h03);
    send_byte(8'h55);
    send_byte(8'hA3);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'hFF);
    check("tvalid_before_last", {31'd0, m_tvalid}, 32'd0);
    send_byte(8'h09);
`else
    check("tvalid_before_last", {31'd0, m_tvalid}, 32'd0);
    send_byte(8'hFF);
`endif
    check("tvalid_after_last", {31'd0, m_tvalid}, 32'd1);
    check("frame_len_3", {27'd0, frame_len}, 32'd3);
    wait_drain("drain_3");

    // Bad lengths 00 and 11 (17 > MAX_LEN)
    base = len_err_n;
    send_byte(8'h00);
    check("busy_after_len0", {31'd0, busy}, 32'd0);
    send_byte(8'h11);
    check("busy_after_len17", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("len_error_pulses", len_err_n - base, 32'd2);

    // Timeout after 02,11 then recovery with 01,22
    base = to_err_n;
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TO + 3) @(negedge clk);
    check("timeout_pulse", to_err_n - base, 32'd1);
    check("busy_after_timeout", {31'd0, busy}, 32'd0);
    exp_q.push_back({1'b1, 8'h22});
    send_byte(8'h01);
    send_byte(8'h22);
    send_cks(8'h22);
    wait_drain("drain_after_timeout");

    // A byte landing on the terminal idle count wins
    base = to_err_n;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h22);
    send_cks(8'h33);
    wait_drain("drain_terminal_byte");
    check("no_timeout_at_terminal", to_err_n - base, 32'd0);

    // Back-pressure: tdata held for 10 cycles with s_axis_tready low
    m_tready = 1'b0;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_cks(8'h33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_data", {22'd0, m_tvalid, s_tready, m_tdata}, {22'd0, 1'b1, 1'b0, 8'h11});
    end
    check("hold_state", {30'd0, dbg_state}, 32'd3);
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_drain("drain_backpressure");

    // Full-length frame
    for (int i = 0; i < ML; i++) pay[i] = DW'(i * 7 + 3);
    send_frame(ML);
    wait_drain("drain_max_len");
    check("frame_len_max", {27'd0, frame_len}, ML);

`ifdef UART_FRAME_CHECKSUM_EN
    base = ck_err_n;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_drain("drain_cks_good");
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    check("cks_error_pulse", ck_err_n - base, 32'd1);
    check("busy_after_cks_err", {31'd0, busy}, 32'd0);
`else
    check("cks_error_never", ck_err_n, 32'd0);
`endif

    // Reset mid-frame discards the partial frame
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_midrst", {30'd0, busy, m_tvalid}, 32'd0);
    exp_q.push_back({1'b1, 8'h7E});
    send_byte(8'h01);
    send_byte(8'h7E);
    send_cks(8'h7E);
    wait_drain("drain_after_midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
